// File: rtl/lsu_mem_master_pkg.sv
// Shared types for the load/store memory master: access size codes,
// FSM state encodings, RAM write-enable polarity and the alignment rule.
// Imported by the interface user, the lane aligner and the top.
package lsu_mem_master_pkg;

   localparam int ADDR_WIDTH = 32;
   localparam int DATA_WIDTH = 32;

   // RAM write enable is active-high
   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = ~WRITE_ENABLE;

   localparam logic [DATA_WIDTH-1:0] ZERO = '0;

   // Access size as carried on req_size_i
   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10,
      SIZE_X = 2'b11
   } size_e;

   // One request outstanding: IDLE accepts, RESP holds the answer
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RMW_RD = 3'd2,
      WRITE  = 3'd3,
      RESP   = 3'd4
   } state_e;

   // Illegal size, or a half/word whose low address bits break natural alignment
   function automatic logic size_misaligned(size_e size, logic [1:0] lsb);
      logic bad;
      bad = 1'b0;
      case (size)
         SIZE_B:  bad = 1'b0;
         SIZE_H:  bad = lsb[0];
         SIZE_W:  bad = (lsb != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Core request/response channel plus the word RAM port of the LSU.
// master: the LSU side; slave: the core + RAM side driving the inputs.
// Signal names keep their LSU-relative _i/_o affixes for traceability.
interface lsu_mem_master_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   // core request channel
   logic                  req_valid_i;
   logic                  req_ready_o;
   logic                  req_we_i;
   logic [1:0]            req_size_i;
   logic                  req_unsigned_i;
   logic [ADDR_WIDTH-1:0] req_addr_i;
   logic [DATA_WIDTH-1:0] req_wdata_i;

   // core response channel
   logic                  rsp_valid_o;
   logic                  rsp_ready_i;
   logic [DATA_WIDTH-1:0] rsp_rdata_o;
   logic                  rsp_err_o;

   // word-organised RAM port, read data combinational from the address
   logic                  mem_we_o;
   logic [ADDR_WIDTH-1:0] mem_addr_o;
   logic [DATA_WIDTH-1:0] mem_wdata_o;
   logic [DATA_WIDTH-1:0] mem_rdata_i;

   modport master (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      output req_ready_o,
      output rsp_valid_o, rsp_rdata_o, rsp_err_o,
      input  rsp_ready_i,
      output mem_we_o, mem_addr_o, mem_wdata_o,
      input  mem_rdata_i
   );

   modport slave (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
      input  req_ready_o,
      input  rsp_valid_o, rsp_rdata_o, rsp_err_o,
      output rsp_ready_i,
      input  mem_we_o, mem_addr_o, mem_wdata_o,
      output mem_rdata_i
   );

endinterface

// File: rtl/lsu_mem_master_lane_align.sv
// Byte-lane helper: store merge into a RAM word, load extract with sign/zero
// extension, and the request alignment check. Purely combinational.
// Lanes are little-endian: byte lane = addr[1:0], half lane = addr[1].
module lsu_lane_align
   import lsu_mem_master_pkg::*;
(
   // alignment check on the incoming request
   input  size_e       chk_size,
   input  logic [1:0]  chk_lsb,
   output logic        misaligned,
   // merge/extract on the latched request
   input  size_e       size,
   input  logic [1:0]  lane,
   input  logic        unsgn,
   input  logic [31:0] store_data,
   input  logic [31:0] mem_word,
   output logic [31:0] merged,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        fill;

   assign misaligned = size_misaligned(chk_size, chk_lsb);

   // Replace only the addressed lane(s) of the RAM word; a word store takes the data whole
   always_comb begin
      merged = mem_word;
      case (size)
         SIZE_B: begin
            case (lane)
               2'd0:    merged[7:0]   = store_data[7:0];
               2'd1:    merged[15:8]  = store_data[7:0];
               2'd2:    merged[23:16] = store_data[7:0];
               default: merged[31:24] = store_data[7:0];
            endcase
         end
         SIZE_H: begin
            if (lane[1]) merged[31:16] = store_data[15:0];
            else         merged[15:0]  = store_data[15:0];
         end
         default: merged = store_data;
      endcase
   end

   // Pick the addressed lane and extend it; unsigned has no effect on words
   always_comb begin
      byte_sel  = mem_word[{lane, 3'b000} +: 8];
      half_sel  = lane[1] ? mem_word[31:16] : mem_word[15:0];
      fill      = 1'b0;
      load_data = mem_word;
      case (size)
         SIZE_B: begin
            fill      = ~unsgn & byte_sel[7];
            load_data = {{24{fill}}, byte_sel};
         end
         SIZE_H: begin
            fill      = ~unsgn & half_sel[15];
            load_data = {{16{fill}}, half_sel};
         end
         default: load_data = mem_word;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator for a word-wide RAM; sub-word stores done as read-modify-write.
// Latency from acceptance: error 1, load 2, word store 2, sub-word store 3 cycles.
// One request outstanding: req_ready_o low until the response is taken (rsp_ready_i).
module lsu_mem_master
   import lsu_mem_master_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   lsu_mem_master_if.master  bus
);

   state_e                state;

   // latched request
   logic                  lat_we;
   size_e                 lat_size;
   logic                  lat_unsigned;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;

   // registered outputs
   logic                  req_ready;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;

   // lane helper results
   logic                  req_misaligned;
   logic [DATA_WIDTH-1:0] merged;
   logic [DATA_WIDTH-1:0] load_data;

   logic                  accept;
   size_e                 req_size;

   assign req_size = size_e'(bus.req_size_i);
   assign accept   = bus.req_valid_i & req_ready;

   lsu_lane_align u_lane_align (
      .chk_size   (req_size),
      .chk_lsb    (bus.req_addr_i[1:0]),
      .misaligned (req_misaligned),
      .size       (lat_size),
      .lane       (lat_addr[1:0]),
      .unsgn      (lat_unsigned),
      .store_data (lat_wdata),
      .mem_word   (bus.mem_rdata_i),
      .merged     (merged),
      .load_data  (load_data)
   );

   // Request FSM: accept, access RAM, hold the response until the core takes it
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= IDLE;
         lat_we       <= 1'b0;
         lat_size     <= SIZE_B;
         lat_unsigned <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= '0;
         req_ready    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_err      <= 1'b0;
         mem_we       <= WRITE_DISABLE;
         mem_addr     <= '0;
         mem_wdata    <= '0;
      end else begin
         // the write strobe is only ever a single-cycle pulse
         mem_we <= WRITE_DISABLE;
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  lat_we       <= bus.req_we_i;
                  lat_size     <= req_size;
                  lat_unsigned <= bus.req_unsigned_i;
                  lat_addr     <= bus.req_addr_i;
                  lat_wdata    <= bus.req_wdata_i;
                  req_ready    <= 1'b0;
                  if (req_misaligned) begin
                     // answer straight away, RAM port left untouched
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= ZERO;
                     state     <= RESP;
                  end else if (!bus.req_we_i) begin
                     mem_addr <= bus.req_addr_i;
                     state    <= LOAD;
                  end else if (req_size == SIZE_W) begin
                     mem_addr  <= bus.req_addr_i;
                     mem_wdata <= bus.req_wdata_i;
                     mem_we    <= WRITE_ENABLE;
                     state     <= WRITE;
                  end else begin
                     mem_addr <= bus.req_addr_i;
                     state    <= RMW_RD;
                  end
               end
            end
            LOAD, WRITE: begin
               // LOAD samples the RAM word here; WRITE has just committed
               rsp_valid <= 1'b1;
               rsp_err   <= 1'b0;
               rsp_rdata <= lat_we ? ZERO : load_data;
               state     <= RESP;
            end
            RMW_RD: begin
               // old word is on mem_rdata_i now; the write goes out next cycle
               mem_wdata <= merged;
               mem_we    <= WRITE_ENABLE;
               state     <= WRITE;
            end
            RESP: begin
               if (bus.rsp_ready_i) begin
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= ZERO;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               req_ready <= 1'b0;
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready_o = req_ready;
   assign bus.rsp_valid_o = rsp_valid;
   assign bus.rsp_rdata_o = rsp_rdata;
   assign bus.rsp_err_o   = rsp_err;
   assign bus.mem_we_o    = mem_we;
   assign bus.mem_addr_o  = mem_addr;
   assign bus.mem_wdata_o = mem_wdata;

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator that drives the word-organised data RAM port: write enable, word address, write data, combinational read data.
- Accepts byte, halfword and word requests from the core over a valid/ready handshake. Returns sign- or zero-extended load data.
- Implements sub-word stores as read-modify-write, because the RAM only writes whole words.
- Checks alignment and returns an error response for misaligned or illegal requests without touching memory.

Parameters:
- ADDR_WIDTH, 32, byte address width on both request and memory sides.
- DATA_WIDTH, 32, data word width; fixed at 32, byte lanes assumed.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  block can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  zero-extend loads (ignored for word and for stores)
- req_addr_i  in  ADDR_WIDTH  byte address
- req_wdata_i  in  DATA_WIDTH  store data, right-aligned
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_rdata_o  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err_o  out  1  misaligned or illegal-size request
- mem_we_o  out  1  RAM write enable (active-high, `WRITE_ENABLE)
- mem_addr_o  out  ADDR_WIDTH  RAM byte address; RAM uses bits [RAM_ADDR_WIDTH-1:2]
- mem_wdata_o  out  DATA_WIDTH  RAM write word
- mem_rdata_i  in  DATA_WIDTH  RAM read word, combinational from mem_addr_o

Behaviour:
- Reset (rst_ni low, asynchronous): state IDLE; all outputs 0, including req_ready_o; latched request registers 0.
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE:
  - req_ready_o = 1.
  - On req_valid_i, latch addr/size/we/unsigned/wdata.
  - Error if size == 11, or half with addr[0] set, or word with addr[1:0] != 0. Error → RESP with err = 1.
  - Otherwise: load → LOAD; word store → WRITE; byte/half store → RMW_RD.
- LOAD:
  - mem_addr_o = latched addr; mem_rdata_i sampled at the clock edge.
  - Selected lane extended into the response register → RESP.
- RMW_RD:
  - mem_addr_o = addr; sample mem_rdata_i.
  - Merge the store byte into lane addr[1:0], or the store half into lane addr[1]; other lanes preserved.
  - → WRITE.
- WRITE:
  - mem_we_o = 1 for exactly one cycle; mem_wdata_o = merged word (or req_wdata for a word store).
  - → RESP.
- RESP:
  - rsp_valid_o = 1; rsp_rdata_o and rsp_err_o stable while valid.
  - Advance to IDLE only when rsp_ready_i = 1.
  - req_ready_o = 0 (no overlap; one request outstanding).
- Lanes are little-endian:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Signed loads replicate the lane MSB; unsigned loads pad with 0.
- Latency, from the acceptance edge T to the first rsp_valid_o cycle:
  - Load: T+2.
  - Word store: T+2, with the write committed at the end of T+1.
  - Sub-word store: T+3.
  - Error: T+1.
- Outside WRITE, mem_we_o = 0; mem_addr_o and mem_wdata_o hold their last values.
- Throughput is one request per latency + 1 cycles when rsp_ready_i is tied high.
- Reset mid-operation: mem_we_o drops immediately. A reset during RMW_RD leaves memory unchanged (no partial write). The pending response is discarded.
- req_valid_i outside IDLE is ignored (ready is 0).

Decomposition:
- Add to defines.v: size codes (SIZE_B, SIZE_H, SIZE_W), FSM state encodings, and reuse of `WRITE_ENABLE, `ZERO, `ADDR_WIDTH, `DATA_WIDTH.
- One natural combinational sub-module: lsu_lane_align, covering store merge by lane, load extract with sign/zero extension, and the misalignment check.
- The FSM stays in lsu_mem_master.

Test Plan:
- Word store then load: store 0xDEADBEEF @0x10; load word @0x10 → mem_we_o high for one cycle at T+1; load rsp_rdata_o = 0xDEADBEEF at T+2, err = 0.
- Byte RMW: mem[0x20] = 0x11223344; store byte 0xAB @0x22 → RAM word becomes 0x11AB3344, one write pulse; signed LB @0x22 → 0xFFFFFFAB; LBU @0x22 → 0x000000AB.
- Half access: store half 0x8001 @0x32 over 0x00000000 → 0x80010000; LH @0x32 → 0xFFFF8001; LHU @0x32 → 0x00008001.
- Errors: LW @0x05, SH @0x07, size 11 @0x00 → rsp_err_o = 1 at T+1, rsp_rdata_o = 0, mem_we_o never asserted, memory unchanged.
- Response backpressure: hold rsp_ready_i = 0 for 5 cycles on a load → rsp_valid_o and data stable; req_ready_o = 0; new req_valid_i ignored; accepted after release.
- Reset in RMW_RD: assert rst_ni low during the RMW_RD cycle of SB @0x20 → mem_we_o = 0 immediately; word at 0x20 unchanged; after release, outputs 0 and state IDLE.
